// File: rtl/key_debounce_sync.sv
// Key debouncer: 2-FF synchroniser plus a counter-qualified FSM.
// Drives a clean registered level and one-cycle rise/fall strobes.
module key_debounce_sync #(
    parameter int STABLE_CYCLES = 1000000,
    parameter int CNT_W         = 20
) (
    input  logic CLK,
    input  logic RST,
    input  logic KEY_IN,
    output logic D_OUT,
    output logic RISE,
    output logic FALL,
    output logic BUSY
);

    typedef enum logic [1:0] {
        S_LOW   = 2'b00,
        S_CHK_H = 2'b01,
        S_HIGH  = 2'b10,
        S_CHK_L = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    logic             s1;
    logic             s2;
    logic [CNT_W-1:0] cnt;
    state_t           state;

    always_ff @(posedge CLK) begin
        if (RST) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            cnt   <= '0;
            state <= S_LOW;
            D_OUT <= 1'b0;
            RISE  <= 1'b0;
            FALL  <= 1'b0;
        end else begin
            s1   <= KEY_IN;
            s2   <= s1;
            RISE <= 1'b0;
            FALL <= 1'b0;
            unique case (state)
                S_LOW: begin
                    if (s2) begin
                        state <= S_CHK_H;
                        cnt   <= ONE;
                    end else begin
                        cnt <= '0;
                    end
                end
                S_CHK_H: begin
                    if (!s2) begin
                        state <= S_LOW;
                        cnt   <= '0;
                    end else if (cnt == LAST) begin
                        state <= S_HIGH;
                        D_OUT <= 1'b1;
                        RISE  <= 1'b1;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end
                S_HIGH: begin
                    if (!s2) begin
                        state <= S_CHK_L;
                        cnt   <= ONE;
                    end else begin
                        cnt <= '0;
                    end
                end
                S_CHK_L: begin
                    // any sample back at the stable level aborts the fall
                    if (s2) begin
                        state <= S_HIGH;
                        cnt   <= '0;
                    end else if (cnt == LAST) begin
                        state <= S_LOW;
                        D_OUT <= 1'b0;
                        FALL  <= 1'b1;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end
                default: begin
                    state <= S_LOW;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign BUSY = (state == S_CHK_H) || (state == S_CHK_L);

endmodule

// File: tb/tb_key_debounce_sync.sv
// Bench for key_debounce_sync: vector table, corner sequences, and
// random key activity checked against a sliding-window model.
module tb_key_debounce_sync;

    localparam int N = 4;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic KEY_IN = 1'b0;
    logic D_OUT, RISE, FALL, BUSY;

    int checks = 0;
    int failures = 0;

    key_debounce_sync #(.STABLE_CYCLES(N), .CNT_W(3)) dut (
        .CLK(CLK),
        .RST(RST),
        .KEY_IN(KEY_IN),
        .D_OUT(D_OUT),
        .RISE(RISE),
        .FALL(FALL),
        .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    // model: synchroniser as 2-deep delay line, commit when the
    // last N synchronised samples all differ from the output level
    logic [1:0] m_dl = 2'b00;
    logic       m_win[$];
    logic       m_d = 1'b0;
    logic       m_rise = 1'b0;
    logic       m_fall = 1'b0;
    logic       m_busy = 1'b0;

    task automatic model_step(input logic rst, input logic key);
        int run;
        logic v;
        m_rise = 1'b0;
        m_fall = 1'b0;
        if (rst) begin
            m_dl = 2'b00;
            m_win.delete();
            m_d = 1'b0;
            m_busy = 1'b0;
        end else begin
            v = m_dl[1];
            m_dl = {m_dl[0], key};
            m_win.push_back(v);
            if (m_win.size() > N) void'(m_win.pop_front());
            run = 0;
            for (int i = m_win.size() - 1; i >= 0; i--) begin
                if (m_win[i] == m_d) break;
                run++;
            end
            if (run == N) begin
                m_d = ~m_d;
                m_rise = m_d;
                m_fall = ~m_d;
                m_busy = 1'b0;
            end else begin
                m_busy = (run > 0);
            end
        end
    endtask

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%b required=%b", name, $time, act, exp);
        end
    endtask

    task automatic tick(input logic rst, input logic key);
        RST = rst;
        KEY_IN = key;
        @(posedge CLK);
        model_step(rst, key);
        #1;
        check("d_out", D_OUT, m_d);
        check("rise", RISE, m_rise);
        check("fall", FALL, m_fall);
        check("busy", BUSY, m_busy);
        check("rise_fall_excl", RISE & FALL, 1'b0);
    endtask

    typedef struct {
        logic rst;
        logic key;
        logic d;
        logic rise;
        logic fall;
        logic busy;
    } vec_t;

    vec_t vt[$];

    function automatic void add(input logic r, input logic k, input logic d,
                                input logic ri, input logic fa, input logic b);
        vec_t x;
        x.rst = r; x.key = k; x.d = d; x.rise = ri; x.fall = fa; x.busy = b;
        vt.push_back(x);
    endfunction

    int rises;
    int rise_idx;
    int falls;
    int guard;
    logic level;
    logic rr;

    initial begin
        // reset with key high, then press held, then release held
        add(1, 1, 0, 0, 0, 0);
        add(1, 1, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 1);
        add(0, 1, 0, 0, 0, 1);
        add(0, 1, 0, 0, 0, 1);
        add(0, 1, 1, 1, 0, 0);
        add(0, 1, 1, 0, 0, 0);
        add(0, 1, 1, 0, 0, 0);
        add(0, 0, 1, 0, 0, 0);
        add(0, 0, 1, 0, 0, 0);
        add(0, 0, 1, 0, 0, 1);
        add(0, 0, 1, 0, 0, 1);
        add(0, 0, 1, 0, 0, 1);
        add(0, 0, 0, 0, 1, 0);
        add(0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0);

        for (int i = 0; i < vt.size(); i++) begin
            tick(vt[i].rst, vt[i].key);
            check($sformatf("vec%0d_d", i), D_OUT, vt[i].d);
            check($sformatf("vec%0d_rise", i), RISE, vt[i].rise);
            check($sformatf("vec%0d_fall", i), FALL, vt[i].fall);
            check($sformatf("vec%0d_busy", i), BUSY, vt[i].busy);
        end

        // bounce 1,0,1,1,0 then steady 1 from index 5
        rises = 0;
        rise_idx = -1;
        begin
            logic bseq[6];
            bseq = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
            for (int i = 0; i < 5; i++) begin
                tick(0, bseq[i]);
                if (RISE) rises++;
            end
        end
        for (int i = 0; i < 12; i++) begin
            tick(0, 1'b1);
            if (RISE) begin
                rises++;
                rise_idx = i;
            end
        end
        check("bounce_one_rise", rises == 1, 1'b1);
        check("bounce_rise_edge6", rise_idx == 5, 1'b1);

        // short glitch while high
        falls = 0;
        for (int i = 0; i < 3; i++) begin
            tick(0, 1'b0);
            if (FALL) falls++;
        end
        for (int i = 0; i < 8; i++) begin
            tick(0, 1'b1);
            if (FALL) falls++;
        end
        check("glitch_no_fall", falls == 0, 1'b1);
        check("glitch_d_high", D_OUT, 1'b1);
        check("glitch_not_busy", BUSY, 1'b0);

        // back to low, then reset at cnt==2
        for (int i = 0; i < 10; i++) tick(0, 1'b0);
        guard = 0;
        tick(0, 1'b1);
        while (dut.cnt != 3'd2 && guard < 10) begin
            tick(0, 1'b1);
            guard++;
        end
        check("midcnt_reached", guard < 10, 1'b1);
        check("midcnt_busy", BUSY, 1'b1);
        tick(1, 1'b1);
        check("midrst_cnt0", dut.cnt == 3'd0, 1'b1);
        check("midrst_slow", dut.state == 2'd0, 1'b1);
        check("midrst_d0", D_OUT, 1'b0);
        check("midrst_norise", RISE, 1'b0);

        // reset landing on the commit edge
        for (int i = 0; i < 5; i++) tick(0, 1'b1);
        check("precommit_busy", BUSY, 1'b1);
        tick(1, 1'b1);
        check("commit_rst_d0", D_OUT, 1'b0);
        check("commit_rst_norise", RISE, 1'b0);

        // random runs with occasional reset
        level = 1'b0;
        for (int s = 0; s < 400; s++) begin
            level = ~level;
            for (int j = 0; j < int'($urandom_range(1, 8)); j++) begin
                rr = ($urandom_range(0, 199) == 0);
                tick(rr, level);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
